// File: rtl/skew_feeder.sv
// skew_feeder: streams LEN input-buffer rows into the systolic array, delaying lane k by k cycles.
// Build macro SKEW_FEEDER_ZERO_FILL_EN: idle lanes drive zero instead of holding their last value.
module skew_feeder #(
  parameter int unsigned ROW_DIM    = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sig_start,
  input  logic [ADDR_WIDTH-1:0]          LEN,
  input  logic [ADDR_WIDTH-1:0]          A_base_addr,
  output logic                           A_r_en,
  output logic [ADDR_WIDTH-1:0]          A_addr,
  input  logic [ROW_DIM*DATA_WIDTH-1:0]  data_in,
  output logic [ROW_DIM*DATA_WIDTH-1:0]  data_out,
  output logic [ROW_DIM-1:0]             valid_out,
  output logic                           sig_end
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   row_cnt;
  logic [ADDR_WIDTH-1:0]   out_cnt;
  logic                    rd_tag;
  logic                    sig_end_q;

  // Valid/data presented to each lane's output register
  logic [ROW_DIM-1:0]      lane_v;
  logic [DATA_WIDTH-1:0]   lane_d [ROW_DIM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (sig_start) state_nxt = (LEN != '0) ? READ : DONE;
      READ:  if (row_cnt == len_q - 1'b1) state_nxt = DRAIN;
      // out_cnt counts rows already handed to the last lane, so this is the final row
      DRAIN: if (lane_v[ROW_DIM-1] && (out_cnt == len_q - 1'b1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    A_r_en = 1'b0;
    A_addr = '0;
    if (state == READ) begin
      A_r_en = 1'b1;
      A_addr = base_q + row_cnt;
    end
  end

  // sig_end is registered off DONE, so IDLE is already live during the pulse cycle
  assign sig_end = sig_end_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      base_q    <= '0;
      row_cnt   <= '0;
      out_cnt   <= '0;
      rd_tag    <= 1'b0;
      sig_end_q <= 1'b0;
    end else begin
      rd_tag    <= A_r_en;
      sig_end_q <= (state == DONE);
      if (state == IDLE && sig_start) begin
        len_q   <= LEN;
        base_q  <= A_base_addr;
        row_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (state == READ)     row_cnt <= row_cnt + 1'b1;
        if (lane_v[ROW_DIM-1]) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < ROW_DIM; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign lane_v[k] = rd_tag;
      assign lane_d[k] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end else if (k == 1) begin : g_one
      logic                  vch;
      logic [DATA_WIDTH-1:0] dch;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vch <= 1'b0;
          dch <= '0;
        end else begin
          vch <= rd_tag;
          dch <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      assign lane_v[k] = vch;
      assign lane_d[k] = dch;
    end else begin : g_chain
      logic [k-1:0]                 vch;
      logic [k-1:0][DATA_WIDTH-1:0] dch;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vch <= '0;
          dch <= '0;
        end else begin
          vch <= {vch[k-2:0], rd_tag};
          dch <= {dch[k-2:0], data_in[k*DATA_WIDTH +: DATA_WIDTH]};
        end
      end
      assign lane_v[k] = vch[k-1];
      assign lane_d[k] = dch[k-1];
    end

    logic                  ov;
    logic [DATA_WIDTH-1:0] oreg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ov   <= 1'b0;
        oreg <= '0;
      end else begin
        ov <= lane_v[k];
`ifdef SKEW_FEEDER_ZERO_FILL_EN
        oreg <= lane_v[k] ? lane_d[k] : '0;
`else
        if (lane_v[k]) oreg <= lane_d[k];
`endif
      end
    end
    assign valid_out[k]                          = ov;
    assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = oreg;
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder: per-cycle comparison against a wavefront model
// derived from the row/lane timing formulas (lane k of row i visible after edge i+2+k).
module tb_skew_feeder;

  localparam int ROW_DIM    = 16;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int W          = ROW_DIM * DATA_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  sig_start = 1'b0;
  logic [ADDR_WIDTH-1:0] LEN = '0;
  logic [ADDR_WIDTH-1:0] A_base_addr = '0;
  logic                  A_r_en;
  logic [ADDR_WIDTH-1:0] A_addr;
  logic [W-1:0]          data_in = '0;
  logic [W-1:0]          data_out;
  logic [ROW_DIM-1:0]    valid_out;
  logic                  sig_end;

  logic [W-1:0]          mem [DEPTH];
  logic [DATA_WIDTH-1:0] last_val [ROW_DIM];
  int                    errors = 0;
  int                    checks = 0;
  int                    cur_t  = 0;

  skew_feeder #(
    .ROW_DIM   (ROW_DIM),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_start  (sig_start),
    .LEN        (LEN),
    .A_base_addr(A_base_addr),
    .A_r_en     (A_r_en),
    .A_addr     (A_addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sig_end    (sig_end)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer; garbage on idle cycles so unqualified data cannot pass unnoticed
  always @(posedge clk)
    data_in <= A_r_en ? mem[A_addr] : {$urandom, $urandom, $urandom, $urandom};

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic int end_edge(input int len);
    return (len == 0) ? 1 : len + ROW_DIM + 1;
  endfunction

  // Expected outputs in the cycle after edge E(t) of a transfer (len, base)
  task automatic check_cycle(input int t, input int len, input int base);
    logic [W-1:0]       exp_d;
    logic [ROW_DIM-1:0] exp_v;
    logic [W-1:0]       row;
    int                 i;
    cur_t = t;
    exp_d = '0;
    exp_v = '0;
    for (int k = 0; k < ROW_DIM; k++) begin
      i = t - 2 - k;
      if (i >= 0 && i < len) begin
        row         = mem[(base + i) % DEPTH];
        exp_v[k]    = 1'b1;
        last_val[k] = row[k*DATA_WIDTH +: DATA_WIDTH];
        exp_d[k*DATA_WIDTH +: DATA_WIDTH] = last_val[k];
      end else begin
`ifdef SKEW_FEEDER_ZERO_FILL_EN
        exp_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`else
        exp_d[k*DATA_WIDTH +: DATA_WIDTH] = last_val[k];
`endif
      end
    end
    check("a_r_en",    W'(A_r_en),    W'(t < len));
    check("a_addr",    W'(A_addr),    (t < len) ? W'((base + t) % DEPTH) : '0);
    check("valid_out", W'(valid_out), W'(exp_v));
    check("data_out",  data_out,      exp_d);
    check("sig_end",   W'(sig_end),   W'(t == end_edge(len)));
  endtask

  // hold=1 keeps sig_start high through the end so the next call starts back-to-back
  task automatic run_xfer(input int len, input int base, input bit hold);
    int last;
    @(negedge clk);
    LEN         = ADDR_WIDTH'(len);
    A_base_addr = ADDR_WIDTH'(base);
    sig_start   = 1'b1;
    @(posedge clk);
    #1 check_cycle(0, len, base);
    last = hold ? end_edge(len) : end_edge(len) + 1;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      if (!hold) sig_start = 1'b0;
      @(posedge clk);
      #1 check_cycle(t, len, base);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_r_en"},    W'(A_r_en),    '0);
    check({tag, "_a_addr"},    W'(A_addr),    '0);
    check({tag, "_data_out"},  data_out,      '0);
    check({tag, "_valid_out"}, W'(valid_out), '0);
    check({tag, "_sig_end"},   W'(sig_end),   '0);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < ROW_DIM; k++) last_val[k] = '0;

    // Power-on reset
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic stream: row i lane k = 16*i + k at addresses 200..202
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < ROW_DIM; k++)
        mem[200 + i][k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(16 * i + k);
    run_xfer(3, 200, 1'b0);
`ifdef SKEW_FEEDER_ZERO_FILL_EN
    check("lane15_after", W'(data_out[W-1 -: DATA_WIDTH]), '0);
`else
    check("lane15_after", W'(data_out[W-1 -: DATA_WIDTH]), W'(8'h2F));
`endif

    // Zero length
    run_xfer(0, 77, 1'b0);

    // Address wrap past the top of the buffer
    run_xfer(4, 1022, 1'b0);

    // Busy start: held request, next transfer accepted right after the pulse cycle
    run_xfer(2, 500, 1'b1);
    run_xfer(3, 10, 1'b1);
    run_xfer(0, 0, 1'b0);

    // Random transfers, including one longer than the lane count
    for (int n = 0; n < 6; n++) begin
      int len;
      len = (n == 3) ? 20 : int'($urandom_range(0, 6));
      run_xfer(len, int'($urandom_range(0, DEPTH - 1)), 1'b0);
    end

    // Reset in the middle of the second read
    @(negedge clk);
    LEN         = ADDR_WIDTH'(5);
    A_base_addr = ADDR_WIDTH'(300);
    sig_start   = 1'b1;
    @(posedge clk);
    #1 check_cycle(0, 5, 300);
    @(negedge clk);
    sig_start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    for (int k = 0; k < ROW_DIM; k++) last_val[k] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1 check_all_zero("post_reset");
    end

    // Feeder still works after the aborted transfer
    run_xfer(2, 40, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
